// File: rtl/mem_burst_responder.sv
// Backing-store responder for cache block traffic: fixed-latency 4-beat refill bursts
// and flow-controlled writeback bursts against a local word array.
module mem_burst_responder #(
    parameter int unsigned WORDS_LOG2 = 2,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  ReqValid,
    input  logic                  ReqWrite,
    input  logic [31:0]           ReqAddr,
    output logic                  ReqReady,
    input  logic [31:0]           WData,
    input  logic                  WValid,
    output logic                  WReady,
    output logic [31:0]           RData,
    output logic                  RValid,
    output logic                  RLast,
    output logic [WORDS_LOG2-1:0] Offset,
    output logic                  Done
);

    localparam int unsigned BaseW = DEPTH_LOG2 - WORDS_LOG2;
    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StLat, StRburst, StWburst} state_e;

    state_e                state_q, state_d;
    logic [BaseW-1:0]      base_q;
    logic [WORDS_LOG2-1:0] offset_q;
    logic [CntW-1:0]       cnt_q;
    logic                  done_q;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic                  accept;
    logic                  last_beat;
    logic                  lat_done;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  unused_addr;

    assign accept    = ReqValid && (state_q == StIdle);
    assign last_beat = &offset_q;
    assign lat_done  = (cnt_q == CntW'(LATENCY - 1));
    assign wr_en     = (state_q == StWburst) && WValid;
    assign word_idx  = {base_q, offset_q};

    // Byte-lane bits and bits above the array aperture alias onto the same block.
    assign unused_addr = ^{ReqAddr[31:DEPTH_LOG2+2], ReqAddr[WORDS_LOG2+1:0]};

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (ReqValid) begin
                    state_d = ReqWrite ? StWburst : StLat;
                end
            end
            StLat: begin
                if (lat_done) begin
                    state_d = StRburst;
                end
            end
            StRburst: begin
                if (last_beat) begin
                    state_d = StIdle;
                end
            end
            StWburst: begin
                if (WValid && last_beat) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ReqReady = 1'b0;
        WReady   = 1'b0;
        RValid   = 1'b0;
        RLast    = 1'b0;
        RData    = '0;
        case (state_q)
            StIdle: ReqReady = 1'b1;
            StRburst: begin
                RValid = 1'b1;
                RLast  = last_beat;
                RData  = mem[word_idx];
            end
            StWburst: WReady = 1'b1;
            default: ;
        endcase
    end

    assign Offset = offset_q;
    assign Done   = done_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            base_q   <= '0;
            offset_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last_beat && ((state_q == StRburst) || wr_en);
            if (accept) begin
                base_q   <= ReqAddr[DEPTH_LOG2+1:WORDS_LOG2+2];
                offset_q <= '0;
                cnt_q    <= '0;
            end else if (state_q == StLat) begin
                cnt_q <= lat_done ? '0 : cnt_q + 1'b1;
            end else if ((state_q == StRburst) || wr_en) begin
                offset_q <= offset_q + 1'b1;
            end
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (!Reset && wr_en) begin
            mem[word_idx] <= WData;
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: refill latency, writeback, stalls,
// back-to-back requests, mid-burst reset and address aliasing.
module tb_mem_burst_responder;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqWrite;
    logic [31:0] ReqAddr;
    logic        ReqReady;
    logic [31:0] WData;
    logic        WValid;
    logic        WReady;
    logic [31:0] RData;
    logic        RValid;
    logic        RLast;
    logic [1:0]  Offset;
    logic        Done;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0][31:0] DA = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    localparam logic [3:0][31:0] DB = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    localparam logic [3:0][31:0] DC = {32'h0000_0088, 32'h0000_0077, 32'h0000_0066, 32'h0000_0055};

    mem_burst_responder #(
        .WORDS_LOG2(2),
        .DEPTH_LOG2(10),
        .LATENCY   (4)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .ReqValid(ReqValid),
        .ReqWrite(ReqWrite),
        .ReqAddr (ReqAddr),
        .ReqReady(ReqReady),
        .WData   (WData),
        .WValid  (WValid),
        .WReady  (WReady),
        .RData   (RData),
        .RValid  (RValid),
        .RLast   (RLast),
        .Offset  (Offset),
        .Done    (Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Called in an IDLE cycle; returns in the Done cycle.
    task automatic do_write(input logic [31:0] addr, input logic [3:0][31:0] d, input int stall);
        ReqValid = 1'b1;
        ReqWrite = 1'b1;
        ReqAddr  = addr;
        chk("wr_accept_ready", {31'd0, ReqReady}, 32'd1);
        tick();
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                for (int s = 0; s < stall; s++) begin
                    WValid = 1'b0;
                    WData  = 32'hBAD0_BAD0;
                    chk("wr_stall_offset", {30'd0, Offset}, 32'd1);
                    chk("wr_stall_wready", {31'd0, WReady}, 32'd1);
                    tick();
                end
            end
            WValid = 1'b1;
            WData  = d[i];
            chk("wr_wready", {31'd0, WReady}, 32'd1);
            chk("wr_offset", {30'd0, Offset}, i);
            chk("wr_rvalid", {31'd0, RValid}, 32'd0);
            chk("wr_busy_ready", {31'd0, ReqReady}, 32'd0);
            chk("wr_done_early", {31'd0, Done}, 32'd0);
            tick();
        end
        WValid = 1'b0;
        chk("wr_done", {31'd0, Done}, 32'd1);
        chk("wr_done_ready", {31'd0, ReqReady}, 32'd1);
        chk("wr_done_wready", {31'd0, WReady}, 32'd0);
        chk("wr_done_offset", {30'd0, Offset}, 32'd0);
    endtask

    // Called in a cycle with ReqReady=1; returns in the Done cycle, or the cycle after a reset.
    task automatic do_read(input logic [31:0] addr, input logic [3:0][31:0] e,
                           input logic [31:0] next_addr, input bit early, input int rst_beat);
        ReqValid = 1'b1;
        ReqWrite = 1'b0;
        ReqAddr  = addr;
        WValid   = 1'b1;
        WData    = 32'hDEAD_BEEF;
        chk("rd_accept_ready", {31'd0, ReqReady}, 32'd1);
        tick();
        ReqValid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("rd_lat_rvalid", {31'd0, RValid}, 32'd0);
            chk("rd_lat_ready", {31'd0, ReqReady}, 32'd0);
            chk("rd_lat_wready", {31'd0, WReady}, 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (early) begin
                ReqValid = 1'b1;
                ReqAddr  = next_addr;
            end
            chk("rd_rvalid", {31'd0, RValid}, 32'd1);
            chk("rd_rdata", RData, e[i]);
            chk("rd_offset", {30'd0, Offset}, i);
            chk("rd_rlast", {31'd0, RLast}, (i == 3) ? 32'd1 : 32'd0);
            chk("rd_burst_ready", {31'd0, ReqReady}, 32'd0);
            chk("rd_burst_wready", {31'd0, WReady}, 32'd0);
            if (i == rst_beat) begin
                Reset = 1'b1;
                tick();
                Reset  = 1'b0;
                WValid = 1'b0;
                chk("rst_rvalid", {31'd0, RValid}, 32'd0);
                chk("rst_offset", {30'd0, Offset}, 32'd0);
                chk("rst_ready", {31'd0, ReqReady}, 32'd1);
                chk("rst_rdata", RData, 32'd0);
                chk("rst_done", {31'd0, Done}, 32'd0);
                chk("rst_rlast", {31'd0, RLast}, 32'd0);
                return;
            end
            tick();
        end
        WValid = 1'b0;
        chk("rd_done", {31'd0, Done}, 32'd1);
        chk("rd_done_rvalid", {31'd0, RValid}, 32'd0);
        chk("rd_done_ready", {31'd0, ReqReady}, 32'd1);
        chk("rd_done_offset", {30'd0, Offset}, 32'd0);
        chk("rd_done_rlast", {31'd0, RLast}, 32'd0);
    endtask

    initial begin
        Reset    = 1'b1;
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        ReqAddr  = 32'd0;
        WData    = 32'd0;
        WValid   = 1'b0;
        tick();
        tick();
        chk("reset_ready", {31'd0, ReqReady}, 32'd1);
        chk("reset_wready", {31'd0, WReady}, 32'd0);
        chk("reset_rvalid", {31'd0, RValid}, 32'd0);
        chk("reset_rlast", {31'd0, RLast}, 32'd0);
        chk("reset_done", {31'd0, Done}, 32'd0);
        chk("reset_offset", {30'd0, Offset}, 32'd0);
        chk("reset_rdata", RData, 32'd0);
        Reset = 1'b0;
        tick();

        // Preload block at word 0x40 through the writeback path, then refill it.
        do_write(32'h0000_0100, DA, 0);
        tick();
        chk("done_one_cycle", {31'd0, Done}, 32'd0);
        do_read(32'h0000_0100, DA, 32'd0, 1'b0, -1);
        tick();

        do_write(32'h0000_0200, DB, 0);
        tick();
        do_read(32'h0000_0200, DB, 32'd0, 1'b0, -1);
        tick();

        do_write(32'h0000_0300, DC, 3);
        tick();
        do_read(32'h0000_0300, DC, 32'd0, 1'b0, -1);

        // Back-to-back from the Done cycle; next request is raised during the burst.
        do_read(32'h0000_0104, DA, 32'h0000_1100, 1'b1, -1);
        do_read(32'h0000_1100, DA, 32'd0, 1'b0, -1);
        tick();

        do_read(32'h0000_0200, DB, 32'd0, 1'b0, 2);
        tick();
        do_read(32'h0000_0200, DB, 32'd0, 1'b0, -1);
        tick();
        do_read(32'h0000_0300, DC, 32'd0, 1'b0, -1);
        tick();
        do_read(32'h0000_0100, DA, 32'd0, 1'b0, -1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
